// File: rtl/throw_turn_ctrl.sv
// rtl/throw_turn_ctrl.sv - turn arbitration and per-frame projectile flight for the cat/dog throw game
module throw_turn_ctrl #(
    parameter int DOG_X         = 100,
    parameter int CAT_X         = 860,
    parameter int PLAYER_WIDTH  = 64,
    parameter int PLAYER_HEIGHT = 64,
    parameter int GROUND_Y      = 700,
    parameter int SCREEN_W      = 1024,
    parameter int VY0           = 20,
    parameter int GRAVITY       = 1,
    parameter int FLIGHT_MAX    = 255
) (
    input  logic        clk60MHz,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        dog_throw,
    input  logic        cat_throw,
    input  logic [6:0]  power,
    output logic [10:0] proj_x,
    output logic [10:0] proj_y,
    output logic        proj_visible,
    output logic        turn,
    output logic        busy,
    output logic        hit_dog,
    output logic        hit_cat
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LAUNCH  = 2'd1;
    localparam logic [1:0] S_FLY     = 2'd2;
    localparam logic [1:0] S_RESOLVE = 2'd3;

    localparam logic signed [11:0] X_MAX    = 12'(SCREEN_W - 1);
    localparam logic signed [11:0] Y_GROUND = 12'(GROUND_Y);
    localparam logic signed [11:0] DOG_LO   = 12'(DOG_X);
    localparam logic signed [11:0] DOG_HI   = 12'(DOG_X + PLAYER_WIDTH - 1);
    localparam logic signed [11:0] CAT_LO   = 12'(CAT_X);
    localparam logic signed [11:0] CAT_HI   = 12'(CAT_X + PLAYER_WIDTH - 1);
    localparam logic signed [8:0]  VY_INIT  = 9'(-VY0);

    logic [1:0]         state_q, state_d;
    logic               vblnk_q;
    logic [10:0]        x_q, x_d, y_q, y_d;
    logic [6:0]         vx_q, vx_d;
    logic signed [8:0]  vy_q, vy_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               turn_q, turn_d;
    logic               hit_dog_q, hit_dog_d, hit_cat_q, hit_cat_d;

    logic               tick, req_ok, miss_x, landed, on_target, timeout;
    logic signed [11:0] x_ext, vx_ext, nx, ny;
    logic [7:0]         cnt_next;

    assign tick   = vblnk & ~vblnk_q;
    assign req_ok = turn_q ? cat_throw : dog_throw;

    // The thrower is always the current turn owner, so turn_q also selects direction and target.
    assign x_ext     = signed'({1'b0, x_q});
    assign vx_ext    = signed'({5'b0, vx_q});
    assign nx        = turn_q ? (x_ext - vx_ext) : (x_ext + vx_ext);
    assign ny        = signed'({1'b0, y_q}) + signed'({{3{vy_q[8]}}, vy_q});
    assign miss_x    = (nx < 12'sd0) || (nx > X_MAX);
    assign landed    = (ny >= Y_GROUND);
    assign on_target = turn_q ? ((nx >= DOG_LO) && (nx <= DOG_HI))
                              : ((nx >= CAT_LO) && (nx <= CAT_HI));
    assign cnt_next  = cnt_q + 8'd1;
    assign timeout   = (cnt_next == 8'(FLIGHT_MAX));

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        cnt_d     = cnt_q;
        turn_d    = turn_q;
        hit_dog_d = 1'b0;
        hit_cat_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    state_d = S_LAUNCH;
                    vx_d    = (power == 7'd0) ? 7'd1 : power;
                    vy_d    = VY_INIT;
                    cnt_d   = 8'd0;
                    x_d     = turn_q ? 11'(CAT_X - 1) : 11'(DOG_X + PLAYER_WIDTH);
                    y_d     = 11'(GROUND_Y - PLAYER_HEIGHT);
                end
            end
            S_LAUNCH: state_d = S_FLY;
            S_FLY: begin
                if (tick) begin
                    vy_d  = vy_q + 9'(GRAVITY);
                    cnt_d = cnt_next;
                    if (miss_x) begin
                        state_d = S_RESOLVE;
                    end else if (landed) begin
                        state_d   = S_RESOLVE;
                        x_d       = nx[10:0];
                        y_d       = 11'(GROUND_Y);
                        hit_dog_d = turn_q & on_target;
                        hit_cat_d = ~turn_q & on_target;
                    end else if (timeout) begin
                        state_d = S_RESOLVE;
                    end else begin
                        x_d = nx[10:0];
                        y_d = (ny < 12'sd0) ? 11'd0 : ny[10:0];
                    end
                end
            end
            default: begin
                turn_d  = ~turn_q;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state_q   <= S_IDLE;
            vblnk_q   <= 1'b0;
            x_q       <= 11'd0;
            y_q       <= 11'd0;
            vx_q      <= 7'd0;
            vy_q      <= 9'sd0;
            cnt_q     <= 8'd0;
            turn_q    <= 1'b0;
            hit_dog_q <= 1'b0;
            hit_cat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vblnk_q   <= vblnk;
            x_q       <= x_d;
            y_q       <= y_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            cnt_q     <= cnt_d;
            turn_q    <= turn_d;
            hit_dog_q <= hit_dog_d;
            hit_cat_q <= hit_cat_d;
        end
    end

    assign proj_x       = x_q;
    assign proj_y       = y_q;
    assign proj_visible = (state_q == S_FLY);
    assign busy         = (state_q != S_IDLE);
    assign turn         = turn_q;
    assign hit_dog      = hit_dog_q;
    assign hit_cat      = hit_cat_q;

endmodule
